// File: rtl/operand_join_if.sv
// rtl/operand_join_if.sv - operand stream inputs and paired-output bundle for operand_join
interface operand_join_if #(
  parameter int ADDR_W = 2
);
  logic [31:0]     a;
  logic            data_available_a;
  logic [31:0]     c;
  logic            data_available_c;
  logic [31:0]     out_a;
  logic [31:0]     out_c;
  logic            data_available_out;
  logic [ADDR_W:0] level_a;
  logic [ADDR_W:0] level_c;
  logic            overflow;
  logic [15:0]     pair_count;

  modport master (
    output a, data_available_a, c, data_available_c,
    input  out_a, out_c, data_available_out, level_a, level_c, overflow, pair_count
  );

  modport slave (
    input  a, data_available_a, c, data_available_c,
    output out_a, out_c, data_available_out, level_a, level_c, overflow, pair_count
  );
endinterface

// File: rtl/operand_join.sv
// rtl/operand_join.sv - aligns two free-running operand streams into registered pairs
module operand_join #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input logic           clk,
  input logic           reset,
  operand_join_if.slave io
);
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       mem_a [DEPTH];
  logic [31:0]       mem_c [DEPTH];
  logic [ADDR_W-1:0] wr_a, rd_a, wr_c, rd_c;
  logic [ADDR_W:0]   lvl_a, lvl_c;

  logic [31:0] out_a_q, out_c_q;
  logic        dav_q, overflow_q;
  logic [15:0] pair_cnt_q;

  logic        empty_a, empty_c, full_a, full_c;
  logic        avail_a, avail_c, fire;
  logic        push_a, push_c, pop_a, pop_c, drop_a, drop_c;
  logic [31:0] sel_a, sel_c;

  // Fire when both operands exist; an empty FIFO is bypassed by the live sample
  always_comb begin
    empty_a = (lvl_a == '0);
    empty_c = (lvl_c == '0);
    full_a  = (lvl_a == FULL_LEVEL);
    full_c  = (lvl_c == FULL_LEVEL);
    avail_a = !empty_a || io.data_available_a;
    avail_c = !empty_c || io.data_available_c;
    fire    = avail_a && avail_c;
    pop_a   = fire && !empty_a;
    pop_c   = fire && !empty_c;
    // On fire a live sample is stored only if the head is being popped (never bypassed twice);
    // without fire it is stored unless the FIFO is full.
    push_a  = io.data_available_a && (fire ? !empty_a : !full_a);
    push_c  = io.data_available_c && (fire ? !empty_c : !full_c);
    drop_a  = io.data_available_a && !fire && full_a;
    drop_c  = io.data_available_c && !fire && full_c;
    sel_a   = empty_a ? io.a : mem_a[rd_a];
    sel_c   = empty_c ? io.c : mem_c[rd_c];
  end

  // FIFO storage; contents survive reset since pointers alone define validity
  always_ff @(posedge clk) begin
    if (!reset && push_a) mem_a[wr_a] <= io.a;
    if (!reset && push_c) mem_c[wr_c] <= io.c;
  end

  // Pointers, levels and registered pair outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_a       <= '0;
      rd_a       <= '0;
      wr_c       <= '0;
      rd_c       <= '0;
      lvl_a      <= '0;
      lvl_c      <= '0;
      out_a_q    <= '0;
      out_c_q    <= '0;
      dav_q      <= 1'b0;
      overflow_q <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      if (push_a) wr_a <= wr_a + ADDR_W'(1);
      if (pop_a)  rd_a <= rd_a + ADDR_W'(1);
      if (push_c) wr_c <= wr_c + ADDR_W'(1);
      if (pop_c)  rd_c <= rd_c + ADDR_W'(1);
      lvl_a <= lvl_a + {{ADDR_W{1'b0}}, push_a} - {{ADDR_W{1'b0}}, pop_a};
      lvl_c <= lvl_c + {{ADDR_W{1'b0}}, push_c} - {{ADDR_W{1'b0}}, pop_c};
      if (fire) begin
        out_a_q    <= sel_a;
        out_c_q    <= sel_c;
        pair_cnt_q <= pair_cnt_q + 16'd1;
      end
      dav_q <= fire;
      if (drop_a || drop_c) overflow_q <= 1'b1;
    end
  end

  assign io.out_a              = out_a_q;
  assign io.out_c              = out_c_q;
  assign io.data_available_out = dav_q;
  assign io.level_a            = lvl_a;
  assign io.level_c            = lvl_c;
  assign io.overflow           = overflow_q;
  assign io.pair_count         = pair_cnt_q;
endmodule

// File: tb/tb_operand_join.sv
// tb/tb_operand_join.sv - directed self-checking bench for operand_join
module tb_operand_join;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  operand_join_if #(.ADDR_W(2)) bus ();

  operand_join #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic va, input logic [31:0] av, input logic vc, input logic [31:0] cv);
    bus.data_available_a = va;
    bus.a                = av;
    bus.data_available_c = vc;
    bus.c                = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
    reset = 1'b0;
    checks++;
    if (bus.out_a !== 32'h0 || bus.out_c !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: out_a=%h out_c=%h expected 0", bus.out_a, bus.out_c);
    end
    checks++;
    if (bus.data_available_out !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: dav=%b ovf=%b expected 0", bus.data_available_out, bus.overflow);
    end
    checks++;
    if (bus.level_a !== 3'd0 || bus.level_c !== 3'd0 || bus.pair_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: la=%0d lc=%0d pc=%0d expected 0", bus.level_a, bus.level_c, bus.pair_count);
    end
  endtask

  task automatic test_aligned();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h3F80_0000, 1'b1, 32'h4000_0000);
      checks++;
      if (bus.data_available_out !== 1'b1 || bus.out_a !== 32'h3F80_0000 || bus.out_c !== 32'h4000_0000) begin
        errors++;
        $display("FAIL aligned_pair[%0d]: dav=%b a=%h c=%h expected 1 3f800000 40000000",
                 i, bus.data_available_out, bus.out_a, bus.out_c);
      end
      checks++;
      if (bus.level_a !== 3'd0 || bus.level_c !== 3'd0) begin
        errors++;
        $display("FAIL aligned_level[%0d]: la=%0d lc=%0d expected 0", i, bus.level_a, bus.level_c);
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (bus.data_available_out !== 1'b0 || bus.pair_count !== 16'd8) begin
      errors++;
      $display("FAIL aligned_end: dav=%b pc=%0d expected 0 8", bus.data_available_out, bus.pair_count);
    end
  endtask

  task automatic test_a_leads();
    logic        va [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [31:0] av [8] = '{1, 2, 3, 4, 5, 0, 0, 0};
    logic        vc [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    logic [31:0] cv [8] = '{0, 0, 0, 101, 102, 103, 104, 105};
    logic [2:0]  ela [8] = '{1, 2, 3, 3, 3, 2, 1, 0};
    logic        edv [8] = '{0, 0, 0, 1, 1, 1, 1, 1};
    logic [31:0] eoa [8] = '{0, 0, 0, 1, 2, 3, 4, 5};
    logic [31:0] eoc [8] = '{0, 0, 0, 101, 102, 103, 104, 105};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(va[i], av[i], vc[i], cv[i]);
      checks++;
      if (bus.level_a !== ela[i] || bus.level_c !== 3'd0 || bus.data_available_out !== edv[i]) begin
        errors++;
        $display("FAIL lead_state[%0d]: la=%0d lc=%0d dav=%b expected %0d 0 %b",
                 i, bus.level_a, bus.level_c, bus.data_available_out, ela[i], edv[i]);
      end
      if (edv[i]) begin
        checks++;
        if (bus.out_a !== eoa[i] || bus.out_c !== eoc[i]) begin
          errors++;
          $display("FAIL lead_pair[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                   i, bus.out_a, bus.out_c, eoa[i], eoc[i]);
        end
      end
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.pair_count !== 16'd5) begin
      errors++;
      $display("FAIL lead_end: ovf=%b pc=%0d expected 0 5", bus.overflow, bus.pair_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(10 + i), 1'b0, 32'h0);
    checks++;
    if (bus.level_a !== 3'd4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_fill: la=%0d ovf=%b expected 4 0", bus.level_a, bus.overflow);
    end
    cyc(1'b1, 32'd14, 1'b0, 32'h0);
    checks++;
    if (bus.level_a !== 3'd4 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: la=%0d ovf=%b expected 4 1", bus.level_a, bus.overflow);
    end
    cyc(1'b0, 32'h0, 1'b1, 32'd200);
    checks++;
    if (bus.data_available_out !== 1'b1 || bus.out_a !== 32'd10 || bus.out_c !== 32'd200
        || bus.level_a !== 3'd3 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pair: dav=%b (%0d,%0d) la=%0d ovf=%b expected 1 (10,200) 3 1",
               bus.data_available_out, bus.out_a, bus.out_c, bus.level_a, bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(10 + i), 1'b0, 32'h0);
    cyc(1'b1, 32'd14, 1'b1, 32'd200);
    checks++;
    if (bus.data_available_out !== 1'b1 || bus.out_a !== 32'd10 || bus.out_c !== 32'd200
        || bus.level_a !== 3'd4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: dav=%b (%0d,%0d) la=%0d ovf=%b expected 1 (10,200) 4 0",
               bus.data_available_out, bus.out_a, bus.out_c, bus.level_a, bus.overflow);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 32'(201 + i));
      checks++;
      if (bus.out_a !== 32'(11 + i) || bus.out_c !== 32'(201 + i) || bus.level_a !== 3'(3 - i)) begin
        errors++;
        $display("FAIL full_drain[%0d]: (%0d,%0d) la=%0d expected (%0d,%0d) %0d",
                 i, bus.out_a, bus.out_c, bus.level_a, 11 + i, 201 + i, 3 - i);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65537; i++) cyc(1'b1, 32'(i), 1'b1, 32'(i + 7));
    checks++;
    if (bus.pair_count !== 16'd1 || bus.out_a !== 32'd65536 || bus.out_c !== 32'd65543) begin
      errors++;
      $display("FAIL wrap: pc=%0d (%0d,%0d) expected 1 (65536,65543)", bus.pair_count, bus.out_a, bus.out_c);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1'b0, 32'h0, 1'b1, 32'd1);
    cyc(1'b0, 32'h0, 1'b1, 32'd2);
    checks++;
    if (bus.level_c !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre: lc=%0d expected 2", bus.level_c);
    end
    reset = 1'b1;
    cyc(1'b1, 32'd5, 1'b1, 32'd6);
    reset = 1'b0;
    checks++;
    if (bus.data_available_out !== 1'b0 || bus.out_a !== 32'h0 || bus.out_c !== 32'h0
        || bus.level_a !== 3'd0 || bus.level_c !== 3'd0 || bus.overflow !== 1'b0 || bus.pair_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: dav=%b (%0d,%0d) la=%0d lc=%0d ovf=%b pc=%0d expected all 0",
               bus.data_available_out, bus.out_a, bus.out_c, bus.level_a, bus.level_c, bus.overflow, bus.pair_count);
    end
    cyc(1'b1, 32'd7, 1'b1, 32'd8);
    checks++;
    if (bus.data_available_out !== 1'b1 || bus.out_a !== 32'd7 || bus.out_c !== 32'd8
        || bus.pair_count !== 16'd1 || bus.level_c !== 3'd0) begin
      errors++;
      $display("FAIL mid_after: dav=%b (%0d,%0d) pc=%0d lc=%0d expected 1 (7,8) 1 0",
               bus.data_available_out, bus.out_a, bus.out_c, bus.pair_count, bus.level_c);
    end
  endtask

  initial begin
    bus.a                = '0;
    bus.c                = '0;
    bus.data_available_a = 1'b0;
    bus.data_available_c = 1'b0;
    test_reset();
    test_aligned();
    test_a_leads();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
